// File: rtl/vga_timing_if.sv
// ============================================================================
//  Module   : vga_timing_if
//  Brief    : Raster timing bundle between the timing generator and pixel logic.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface vga_timing_if;
  logic       pix_en;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    input  pix_en,
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count
  );

  modport slave (
    output pix_en,
    input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count
  );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
//  Module   : vga_timing_gen
//  Brief    : Raster counters, syncs, display-active flag and line/frame strobes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_BOTTOM  = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOP     = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  wire logic   clk,
  input  wire logic   reset,
  vga_timing_if.master vga
);

  localparam int c_h_total    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total    = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam int c_hs_start   = H_DISPLAY + H_FRONT;
  localparam int c_hs_end     = H_DISPLAY + H_FRONT + H_SYNC;
  localparam int c_vs_start   = V_DISPLAY + V_BOTTOM;
  localparam int c_vs_end     = V_DISPLAY + V_BOTTOM + V_SYNC;
  localparam logic [9:0] c_h_max = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_max = 10'(c_v_total - 1);

  if (c_h_total > 1024 || c_v_total > 1024) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic [9:0] r_hpos;
  logic [9:0] r_vpos;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_display_on;
  logic       r_line_start;
  logic       r_frame_start;
  logic [7:0] r_frame_count;

  logic       w_h_last;
  logic       w_v_last;
  logic [9:0] w_hpos_nxt;
  logic [9:0] w_vpos_nxt;
  logic       w_line_start;
  logic       w_frame_start;
  logic       w_hs_act;
  logic       w_vs_act;
  logic       w_display_on;

  // Flags decode the next count so they line up with the counter in the same cycle.
  assign w_h_last      = (r_hpos == c_h_max);
  assign w_v_last      = (r_vpos == c_v_max);
  assign w_hpos_nxt    = w_h_last ? 10'd0 : r_hpos + 10'd1;
  assign w_vpos_nxt    = w_h_last ? (w_v_last ? 10'd0 : r_vpos + 10'd1) : r_vpos;
  assign w_line_start  = (w_hpos_nxt == 10'd0);
  assign w_frame_start = w_line_start && (w_vpos_nxt == 10'd0);
  assign w_hs_act      = (int'(w_hpos_nxt) >= c_hs_start) && (int'(w_hpos_nxt) < c_hs_end);
  assign w_vs_act      = (int'(w_vpos_nxt) >= c_vs_start) && (int'(w_vpos_nxt) < c_vs_end);
  assign w_display_on  = (int'(w_hpos_nxt) < H_DISPLAY) && (int'(w_vpos_nxt) < V_DISPLAY);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hpos        <= c_h_max;
      r_vpos        <= c_v_max;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_display_on  <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'hFF;
    end else if (vga.pix_en) begin
      r_hpos        <= w_hpos_nxt;
      r_vpos        <= w_vpos_nxt;
      r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_display_on  <= w_display_on;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
      if (w_frame_start) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end else begin
      // Strobes last one enabled cycle; everything else holds.
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign vga.hpos        = r_hpos;
  assign vga.vpos        = r_vpos;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.display_on  = r_display_on;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;
  assign vga.frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Brief    : Scoreboard bench for vga_timing_gen on a reduced raster.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 4, VB = 1, VS = 2, VT_ = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VB + VS + VT_;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t sb[$];
  obs_t m_exp;
  int   m_h, m_v;

  vga_timing_if vif();

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT_),
    .SYNC_POL(1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .vga  (vif)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return '{h: vif.hpos, v: vif.vpos, hs: vif.hsync, vs: vif.vsync, de: vif.display_on,
             ls: vif.line_start, fs: vif.frame_start, fc: vif.frame_count};
  endfunction

  // Drives one cycle and pushes the expected post-edge outputs.
  task automatic tick(input logic en, input logic rs);
    reset = rs;
    vif.pix_en = en;
    if (rs) begin
      m_h = HT - 1;
      m_v = VT - 1;
      m_exp = '{h: 10'(HT - 1), v: 10'(VT - 1), hs: 1'b1, vs: 1'b1, de: 1'b0,
                ls: 1'b0, fs: 1'b0, fc: 8'hFF};
    end else if (en) begin
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
      m_exp.h  = 10'(m_h);
      m_exp.v  = 10'(m_v);
      m_exp.hs = !(m_h >= HD + HF && m_h < HD + HF + HS);
      m_exp.vs = !(m_v >= VD + VB && m_v < VD + VB + VS);
      m_exp.de = (m_h < HD) && (m_v < VD);
      m_exp.ls = (m_h == 0);
      m_exp.fs = (m_h == 0) && (m_v == 0);
      if (m_exp.fs) m_exp.fc = m_exp.fc + 8'd1;
    end else begin
      m_exp.ls = 1'b0;
      m_exp.fs = 1'b0;
    end
    sb.push_back(m_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    obs_t first;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      got = sample(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL reset_sb: got=%h exp=%h", got, exp);
      end
    end
    n_tests++;
    if (got.h !== 10'(HT - 1) || got.v !== 10'(VT - 1) || got.fc !== 8'hFF || got.ls !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got h=%0d v=%0d fc=%0d ls=%b exp h=%0d v=%0d fc=255 ls=0",
                         got.h, got.v, got.fc, got.ls, HT - 1, VT - 1);
    end
    tick(1'b1, 1'b0);
    got = sample(); exp = sb.pop_front(); n_tests++;
    if (got !== exp) begin
      n_fail++; $display("FAIL first_sb: got=%h exp=%h", got, exp);
    end
    first = '{h: 10'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, de: 1'b1, ls: 1'b1, fs: 1'b1, fc: 8'd0};
    n_tests++;
    if (got !== first) begin
      n_fail++; $display("FAIL first_cycle: got=%h exp=%h", got, first);
    end
  endtask

  task automatic test_line();
    obs_t got, exp;
    int hs_low = 0, de_cnt = 0, ls_at = -1;
    for (int i = 1; i <= HT; i++) begin
      tick(1'b1, 1'b0);
      got = sample(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL line_sb: got=%h exp=%h", got, exp);
      end
      if (!got.hs) hs_low++;
      if (got.de) de_cnt++;
      if (got.ls) ls_at = i;
    end
    n_tests++;
    if (hs_low != HS) begin
      n_fail++; $display("FAIL hsync_width: got %0d exp %0d", hs_low, HS);
    end
    n_tests++;
    if (de_cnt != HD) begin
      n_fail++; $display("FAIL line_display: got %0d exp %0d", de_cnt, HD);
    end
    n_tests++;
    if (ls_at != HT) begin
      n_fail++; $display("FAIL line_period: got %0d exp %0d", ls_at, HT);
    end
  endtask

  task automatic test_frame();
    obs_t got, exp;
    int fs_seen = 0, t0 = 0, t1 = 0, vs_low = 0, de_cnt = 0;
    logic [7:0] fc0 = '0, fc1 = '0;
    for (int i = 0; i < 2 * FRAME + 5 && fs_seen < 2; i++) begin
      tick(1'b1, 1'b0);
      got = sample(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL frame_sb: got=%h exp=%h", got, exp);
      end
      if (got.fs) begin
        fs_seen++;
        if (fs_seen == 1) begin t0 = i; fc0 = got.fc; end
        else begin t1 = i; fc1 = got.fc; end
      end
      if (fs_seen == 1) begin
        if (!got.vs) vs_low++;
        if (got.de) de_cnt++;
      end
    end
    n_tests++;
    if (fs_seen != 2) begin
      n_fail++; $display("FAIL frame_timeout: got %0d frame starts exp 2", fs_seen);
    end
    n_tests++;
    if (t1 - t0 != FRAME) begin
      n_fail++; $display("FAIL frame_period: got %0d exp %0d", t1 - t0, FRAME);
    end
    n_tests++;
    if (fc1 !== fc0 + 8'd1) begin
      n_fail++; $display("FAIL frame_count_inc: got %0d exp %0d", fc1, fc0 + 8'd1);
    end
    n_tests++;
    if (vs_low != VS * HT) begin
      n_fail++; $display("FAIL vsync_width: got %0d exp %0d", vs_low, VS * HT);
    end
    n_tests++;
    if (de_cnt != HD * VD) begin
      n_fail++; $display("FAIL frame_display: got %0d exp %0d", de_cnt, HD * VD);
    end
  endtask

  task automatic test_pix_en();
    obs_t got, exp;
    logic [9:0] prev_h = vif.hpos;
    logic en;
    int fs_seen = 0, t0 = 0, t1 = 0, bad_strobe = 0, bad_hold = 0;
    for (int i = 0; i < 4 * FRAME + 10 && fs_seen < 2; i++) begin
      en = (i % 2 == 0);
      tick(en, 1'b0);
      got = sample(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL pix_en_sb: got=%h exp=%h", got, exp);
      end
      if (!en && (got.ls || got.fs)) bad_strobe++;
      if (!en && got.h !== prev_h) bad_hold++;
      if (got.fs) begin
        fs_seen++;
        if (fs_seen == 1) t0 = i; else t1 = i;
      end
      prev_h = got.h;
    end
    n_tests++;
    if (fs_seen != 2 || t1 - t0 != 2 * FRAME) begin
      n_fail++; $display("FAIL pix_en_period: got %0d (starts %0d) exp %0d", t1 - t0, fs_seen, 2 * FRAME);
    end
    n_tests++;
    if (bad_strobe != 0) begin
      n_fail++; $display("FAIL strobe_while_idle: got %0d exp 0", bad_strobe);
    end
    n_tests++;
    if (bad_hold != 0) begin
      n_fail++; $display("FAIL hold_while_idle: got %0d exp 0", bad_hold);
    end
  endtask

  task automatic test_mid_reset();
    obs_t got, exp;
    obs_t rst_state, restart;
    logic found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick(1'b1, 1'b0);
      got = sample(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL mid_run_sb: got=%h exp=%h", got, exp);
      end
      found = (got.h == 10'd5) && (got.v == 10'd2);
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL mid_reset_timeout: got no h=5 v=2 exp found");
    end
    tick(1'b1, 1'b1);
    got = sample(); exp = sb.pop_front();
    rst_state = '{h: 10'(HT - 1), v: 10'(VT - 1), hs: 1'b1, vs: 1'b1, de: 1'b0,
                  ls: 1'b0, fs: 1'b0, fc: 8'hFF};
    n_tests++;
    if (got !== rst_state || got !== exp) begin
      n_fail++; $display("FAIL mid_reset_state: got=%h exp=%h", got, rst_state);
    end
    tick(1'b1, 1'b0);
    got = sample(); exp = sb.pop_front();
    restart = '{h: 10'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, de: 1'b1, ls: 1'b1, fs: 1'b1, fc: 8'd0};
    n_tests++;
    if (got !== restart || got !== exp) begin
      n_fail++; $display("FAIL mid_reset_restart: got=%h exp=%h", got, restart);
    end
  endtask

  task automatic test_wrap();
    obs_t got, exp;
    logic [7:0] start_fc = vif.frame_count;
    logic [7:0] prev_fc = '0, last_fc = '0;
    int fs_seen = 0, fc_bad = 0, de_bad = 0, de_cnt = 0;
    for (int i = 0; i < 257 * FRAME && fs_seen < 256; i++) begin
      tick(1'b1, 1'b0);
      got = sample(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL wrap_sb: got=%h exp=%h", got, exp);
      end
      if (got.fs) begin
        fs_seen++;
        if (got.fc !== 8'(start_fc + fs_seen)) fc_bad++;
        prev_fc = last_fc;
        last_fc = got.fc;
        if (fs_seen > 1 && de_cnt != HD * VD) de_bad++;
        de_cnt = 0;
      end
      if (got.de) de_cnt++;
    end
    n_tests++;
    if (fs_seen != 256 || fc_bad != 0) begin
      n_fail++; $display("FAIL frame_count_seq: got %0d bad of %0d starts exp 0 of 256", fc_bad, fs_seen);
    end
    n_tests++;
    if (prev_fc !== 8'd255 || last_fc !== 8'd0) begin
      n_fail++; $display("FAIL frame_count_wrap: got %0d->%0d exp 255->0", prev_fc, last_fc);
    end
    n_tests++;
    if (de_bad != 0) begin
      n_fail++; $display("FAIL display_per_frame: got %0d bad frames exp 0", de_bad);
    end
  endtask

  initial begin
    vif.pix_en = 1'b0;
    test_reset();
    test_line();
    test_frame();
    test_pix_en();
    test_mid_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
